fp24_to_fix: RTL and testbench

- Converts fp24 values to signed two's-complement fixed point. This is the unpack/denormalize direction of the fp24 arithmetic blocks, which normalize and pack.
- Streaming block with a 2-stage pipeline and valid/ready handshakes on both sides.
- Sits between the fp24 datapath and fixed-point consumers such as pixel/colour quantizers and address generators.
- Saturates on overflow and flushes to zero on underflow; each event is reported with a flag.

---
 rtl/fp24_pkg.sv | 29 ++
 rtl/fp24_unpack.sv | 29 ++
 rtl/fp24_to_fix.sv | 124 ++++++++++++
 tb/tb_fp24_to_fix.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp24_pkg.sv
// fp24 shared types and helpers.
// Used by the fp24 unpack and conversion blocks.
package fp24_pkg;

  localparam int FP24_EXP_BIAS  = 63;
  localparam int FP24_MANT_BITS = 16;
  localparam int FP24_SH_W      = 12;

  typedef struct packed {
    logic        sign;
    logic [6:0]  exp;
    logic [15:0] mant;
  } fp24_t;

  typedef struct packed {
    logic                 sign;
    logic [16:0]          sig;
    logic [FP24_SH_W-1:0] sh;
    logic                 zero;
    logic                 ovf;
    logic                 mexact;
    logic                 unf;
  } fp24_s1_t;

  function automatic logic is_zero(fp24_t f);
    return (f.exp == 7'd0) && (f.mant == 16'd0);
  endfunction

endpackage

// File: rtl/fp24_unpack.sv
// fp24 field unpack: sign, significand, shift, zero.
// Purely combinational; shared by the fp24 arithmetic blocks.
module fp24_unpack
  import fp24_pkg::*;
#(
  parameter int FRAC_BITS = 16,
  parameter int EXP_BIAS  = 63
) (
  input  logic [23:0]                 data,
  output logic                        sign,
  output logic [16:0]                 sig,
  output logic signed [FP24_SH_W-1:0] sh,
  output logic                        zero
);

  fp24_t f;

  assign f = fp24_t'(data);

  // Decode fields and the signed alignment shift
  always_comb begin
    sign = f.sign;
    sig  = {1'b1, f.mant};
    sh   = FP24_SH_W'(int'(f.exp) - EXP_BIAS
                       + FRAC_BITS - FP24_MANT_BITS);
    zero = is_zero(f);
  end

endmodule

// File: rtl/fp24_to_fix.sv
// fp24 to signed fixed-point converter.
// Two-stage pipeline, saturating, flush-to-zero.
module fp24_to_fix
  import fp24_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 16,
  parameter int EXP_BIAS  = 63
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [23:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_unf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [WIDTH-1:0] MAX_POS =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};

  logic                        u_sign;
  logic [16:0]                 u_sig;
  logic signed [FP24_SH_W-1:0] u_sh;
  logic                        u_zero;

  fp24_s1_t   s1_next;
  fp24_s1_t   s1;
  logic       s1_valid;
  logic       s2_valid;
  logic       s1_en;
  logic       s2_en;
  logic [WIDTH-1:0] mag;
  logic [WIDTH-1:0] res;
  int         sh1;
  int         sh2;

  fp24_unpack #(
    .FRAC_BITS (FRAC_BITS),
    .EXP_BIAS  (EXP_BIAS)
  ) u_unpack (
    .data (in_data),
    .sign (u_sign),
    .sig  (u_sig),
    .sh   (u_sh),
    .zero (u_zero)
  );

  assign s2_en     = !s2_valid || out_ready;
  assign s1_en     = !s1_valid || s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s2_valid;

  // Classify range before shifting so that large
  // shifts never pass through the shifter.
  always_comb begin
    sh1            = int'(u_sh);
    s1_next        = '0;
    s1_next.sign   = u_sign;
    s1_next.sig    = u_sig;
    s1_next.sh     = u_sh;
    s1_next.zero   = u_zero;
    s1_next.ovf    = !u_zero &&
      ((sh1 >= WIDTH - 16) ||
       ((sh1 == WIDTH - 17) &&
        (!u_sign || (u_sig[15:0] != 16'd0))));
    s1_next.mexact = !u_zero && (sh1 == WIDTH - 17) &&
                     u_sign && (u_sig[15:0] == 16'd0);
    s1_next.unf    = !u_zero && (sh1 < -16);
  end

  // Stage 1 register: unpacked operand and class
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) s1 <= s1_next;
    end
  end

  // Align, then apply sign with saturation
  always_comb begin
    sh2 = int'($signed(s1.sh));
    mag = '0;
    if (sh2 >= 0)
      mag = WIDTH'(s1.sig) << sh2;
    else
      mag = WIDTH'(s1.sig >> (-sh2));
    res = '0;
    if (s1.zero || s1.unf)
      res = '0;
    else if (s1.ovf)
      res = s1.sign ? MIN_NEG : MAX_POS;
    else if (s1.mexact)
      res = MIN_NEG;
    else
      res = s1.sign ? (~mag + 1'b1) : mag;
  end

  // Stage 2 register: final result and flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_ovf  <= 1'b0;
      out_unf  <= 1'b0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= res;
        out_ovf  <= s1.ovf;
        out_unf  <= s1.unf;
      end
    end
  end

endmodule

// File: tb/tb_fp24_to_fix.sv
// Self-checking bench for fp24_to_fix.
// Random stimulus against an arithmetic reference model.
module tb_fp24_to_fix;

  logic        clk;
  logic        rst;
  logic [23:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_unf;
  logic        out_valid;
  logic        out_ready;

  typedef struct {
    logic [31:0] d;
    logic        ovf;
    logic        unf;
    int          c;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  int          outs = 0;
  bit          lat_on = 0;
  bit          use_dir = 0;
  exp_t        dir_exp;
  bit          stall_prev = 0;
  logic [33:0] held;
  bit          acc;

  fp24_to_fix #(
    .WIDTH     (32),
    .FRAC_BITS (16),
    .EXP_BIAS  (63)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               tag, got, want, $time);
    end
  endtask

  // value = (-1)^s * (1 + m/2^16) * 2^(e-63), scaled by 2^16
  function automatic exp_t model(logic [23:0] x);
    exp_t   r;
    int     e;
    int     sh;
    longint sig;
    longint mag;
    bit     big;
    e   = int'(x[22:16]);
    sig = 65536 + longint'(x[15:0]);
    sh  = e - 63;
    big = 0;
    mag = 0;
    r.d = 0; r.ovf = 0; r.unf = 0; r.c = 0;
    if (e == 0 && x[15:0] == 0) return r;
    if (sh > 40) big = 1;
    else if (sh >= 0) mag = sig * (longint'(1) << sh);
    else if (sh >= -16) mag = sig / (longint'(1) << -sh);
    if (!x[23]) begin
      if (big || mag > (longint'(1) << 31) - 1) begin
        r.d = 32'h7fffffff; r.ovf = 1;
      end else r.d = 32'(mag);
    end else begin
      if (big || mag > (longint'(1) << 31)) begin
        r.d = 32'h80000000; r.ovf = 1;
      end else r.d = 32'(-mag);
    end
    r.unf = !big && mag == 0;
    return r;
  endfunction

  function automatic logic [23:0] rnd();
    logic [23:0] x;
    x = 24'($urandom);
    if ($urandom_range(0, 3) != 0)
      x[22:16] = 7'($urandom_range(44, 80));
    return x;
  endfunction

  // one cycle: inputs already driven at the falling edge
  task automatic step();
    exp_t e;
    #1;
    cyc++;
    acc = 0;
    if (stall_prev) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", 64'({out_ovf, out_unf, out_data}),
          64'(held));
    end
    chk("in_ready", 64'(in_ready),
        64'(!(q.size() == 2 && !out_ready)));
    if (out_valid && out_ready) begin
      outs++;
      if (q.size() == 0) begin
        chk("spurious_out", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        chk("data", 64'(out_data), 64'(e.d));
        chk("ovf", 64'(out_ovf), 64'(e.ovf));
        chk("unf", 64'(out_unf), 64'(e.unf));
        if (lat_on) chk("latency", 64'(cyc - e.c), 64'd2);
      end
    end
    if (in_valid && in_ready) begin
      acc = 1;
      e = use_dir ? dir_exp : model(in_data);
      e.c = cyc;
      q.push_back(e);
    end
    stall_prev = out_valid && !out_ready;
    held = {out_ovf, out_unf, out_data};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_dir(logic [23:0] x, logic [31:0] d,
                          logic ovf, logic unf);
    dir_exp.d = d; dir_exp.ovf = ovf;
    dir_exp.unf = unf; dir_exp.c = 0;
    use_dir = 1;
    in_valid = 1; in_data = x;
    step();
    use_dir = 0;
    in_valid = 0;
    repeat (3) step();
    chk("dir_drain", 64'(q.size()), 64'd0);
  endtask

  task automatic drain(int budget);
    for (int i = 0; i < budget && q.size() != 0; i++)
      step();
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int sent;
    rst = 0; in_valid = 0; in_data = 0; out_ready = 1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_flags", 64'({out_ovf, out_unf}), 64'd0);
    rst = 1;
    #1;
    chk("rst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    lat_on = 1;
    send_dir(24'h3F0000, 32'h00010000, 0, 0);
    send_dir(24'hC04000, 32'hFFFD8000, 0, 0);
    send_dir(24'h000000, 32'h00000000, 0, 0);
    send_dir(24'h800000, 32'h00000000, 0, 0);
    send_dir(24'h4E0000, 32'h7FFFFFFF, 1, 0);
    send_dir(24'hCE0000, 32'h80000000, 0, 0);
    send_dir(24'hCF0000, 32'h80000000, 1, 0);
    send_dir(24'h7FFFFF, 32'h7FFFFFFF, 1, 0);
    send_dir(24'h2E0000, 32'h00000000, 0, 1);
    send_dir(24'h2F0000, 32'h00000001, 0, 0);
    send_dir(24'h018000, 32'h00000000, 0, 1);

    // random backpressure
    lat_on = 0;
    sent = 0;
    for (int i = 0; i < 300 && (sent < 8 || q.size() != 0); i++) begin
      if (!in_valid || acc) begin
        in_valid = (sent < 8) && ($urandom_range(0, 3) != 0);
        in_data = rnd();
      end
      out_ready = 1'($urandom_range(0, 1));
      step();
      if (acc) sent++;
    end
    in_valid = 0;
    out_ready = 1;
    chk("bp_sent", 64'(sent), 64'd8);
    drain(10);

    // full throughput
    lat_on = 1;
    outs = 0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1; in_data = rnd();
      step();
    end
    in_valid = 0;
    drain(10);
    chk("tput_count", 64'(outs), 64'd100);

    // reset with both stages full
    lat_on = 0;
    out_ready = 0;
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_data = rnd();
      step();
    end
    in_valid = 0;
    chk("full_valid", 64'(out_valid), 64'd1);
    #3 rst = 0;
    #1;
    chk("async_valid", 64'(out_valid), 64'd0);
    chk("async_data", 64'(out_data), 64'd0);
    q.delete();
    stall_prev = 0;
    @(negedge clk);
    rst = 1;
    out_ready = 1;
    lat_on = 1;
    in_valid = 1; in_data = 24'h404000;
    step();
    in_valid = 0;
    drain(10);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
